// File: rtl/mem_arb_pkg.sv
// Shared types and grant selection for the IF / load-store memory port arbiter.
// Round-robin arbitration is enabled with MEM_ARB_RR_EN (see mem_port_arbiter).
package mem_arb_pkg;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   pending;
    owner_t owner;
    logic   is_write;
  } rsp_tag_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } grant_t;

  // On contention the requester other than 'last' wins; a lone requester always wins.
  function automatic grant_t pick_owner(input logic if_v, input logic d_v, input owner_t last);
    grant_t g;
    g.valid = if_v | d_v;
    if (if_v && d_v)
      g.owner = (last == OWNER_DATA) ? OWNER_FETCH : OWNER_DATA;
    else if (d_v)
      g.owner = OWNER_DATA;
    else
      g.owner = OWNER_FETCH;
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and load/store requests onto one sync-read memory port and routes responses back.
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed priority (D over IF).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             if_req_valid,
  output logic             if_req_ready,
  input  logic [WIDTH-1:0] if_req_addr,
  output logic             if_rsp_valid,
  output logic [WIDTH-1:0] if_rsp_data,

  input  logic             d_req_valid,
  output logic             d_req_ready,
  input  logic [WIDTH-1:0] d_req_addr,
  input  logic             d_req_we,
  input  logic [WIDTH-1:0] d_req_wdata,
  output logic             d_rsp_valid,
  output logic [WIDTH-1:0] d_rsp_data,

  output logic [WIDTH-1:0] mem_address,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data
);

  grant_t   grant;
  owner_t   prio_last;
  logic     accept;
  rsp_tag_t rsp_tag;

`ifdef MEM_ARB_RR_EN
  owner_t last_grant;

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= OWNER_DATA;
    else if (accept)
      last_grant <= grant.owner;
  end

  assign prio_last = last_grant;
`else
  // Treating IF as the permanent "last winner" makes D win every contention.
  assign prio_last = OWNER_FETCH;
`endif

  assign grant  = pick_owner(if_req_valid, d_req_valid, prio_last);
  assign accept = !rst && grant.valid;

  assign if_req_ready = accept && (grant.owner == OWNER_FETCH);
  assign d_req_ready  = accept && (grant.owner == OWNER_DATA);

  always_comb begin
    mem_address    = '0;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    if (accept) begin
      if (grant.owner == OWNER_FETCH) begin
        mem_address = if_req_addr;
      end else begin
        mem_address    = d_req_addr;
        mem_write_en   = d_req_we;
        mem_write_data = d_req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_tag <= rsp_tag_t'{pending: 1'b0, owner: OWNER_DATA, is_write: 1'b0};
    end else begin
      rsp_tag.pending <= accept;
      if (accept) begin
        rsp_tag.owner    <= grant.owner;
        rsp_tag.is_write <= (grant.owner == OWNER_DATA) && d_req_we;
      end
    end
  end

  // Gated by rst so a response already in flight is dropped in the reset cycle itself.
  assign if_rsp_valid = !rst && rsp_tag.pending && (rsp_tag.owner == OWNER_FETCH);
  assign d_rsp_valid  = !rst && rsp_tag.pending && (rsp_tag.owner == OWNER_DATA);

  assign if_rsp_data = if_rsp_valid ? mem_read_data : '0;
  assign d_rsp_data  = (d_rsp_valid && !rsp_tag.is_write) ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus contention and reset sequences.
// Expectations for contention follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  mem_port_arbiter #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_data    (if_rsp_data),
    .d_req_valid    (d_req_valid),
    .d_req_ready    (d_req_ready),
    .d_req_addr     (d_req_addr),
    .d_req_we       (d_req_we),
    .d_req_wdata    (d_req_wdata),
    .d_rsp_valid    (d_rsp_valid),
    .d_rsp_data     (d_rsp_data),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: single port, one-cycle read latency.
  logic [31:0] mem [256];
  logic [31:0] shadow [256];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[9:2]] <= mem_write_data;
    mem_read_data <= mem[mem_address[9:2]];
  end

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        r;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        eir;
    logic        edr;
  } vec_t;
  vec_t vt[14];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle: drive at negedge, check combinational grant and last cycle's response, score the accept.
  task automatic cyc(input logic r, input logic iv, input logic [31:0] ia,
                     input logic dv, input logic dwe, input logic [31:0] da,
                     input logic [31:0] dwd, input logic eir, input logic edr);
    exp_t e;
    @(negedge clk);
    rst = r; if_req_valid = iv; if_req_addr = ia;
    d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd;
    #1;
    if (r) sb.delete();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("if_rsp_valid", {31'd0, if_rsp_valid}, {31'd0, !e.is_d});
      chk("d_rsp_valid",  {31'd0, d_rsp_valid},  {31'd0, e.is_d});
      chk("if_rsp_data",  if_rsp_data, e.is_d ? 32'd0 : e.data);
      chk("d_rsp_data",   d_rsp_data,  e.is_d ? e.data : 32'd0);
    end else begin
      chk("idle_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
      chk("idle_d_rsp_valid",  {31'd0, d_rsp_valid},  32'd0);
      chk("idle_if_rsp_data",  if_rsp_data, 32'd0);
      chk("idle_d_rsp_data",   d_rsp_data,  32'd0);
    end
    chk("if_req_ready", {31'd0, if_req_ready}, {31'd0, eir});
    chk("d_req_ready",  {31'd0, d_req_ready},  {31'd0, edr});
    if (eir) begin
      chk("mem_address_if", mem_address, ia);
      chk("mem_write_en_if", {31'd0, mem_write_en}, 32'd0);
      e.is_d = 1'b0;
      e.data = shadow[ia[9:2]];
      sb.push_back(e);
    end else if (edr) begin
      chk("mem_address_d", mem_address, da);
      chk("mem_write_en_d", {31'd0, mem_write_en}, {31'd0, dwe});
      chk("mem_write_data_d", mem_write_data, dwe ? dwd : 32'd0);
      e.is_d = 1'b1;
      e.data = dwe ? 32'd0 : shadow[da[9:2]];
      if (dwe) shadow[da[9:2]] = dwd;
      sb.push_back(e);
    end else begin
      chk("mem_address_none", mem_address, 32'd0);
      chk("mem_write_en_none", {31'd0, mem_write_en}, 32'd0);
      chk("mem_write_data_none", mem_write_data, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'hC0DE_0000 + i;
      shadow[i] = 32'hC0DE_0000 + i;
    end
    rst = 1'b1; if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;

    //            r  iv ia        dv dwe da        dwd            eir edr
    vt[0]  = '{1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 32'h04, 32'h0,        1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 32'h08, 1'b1, 1'b1, 32'h0C, 32'h1111,     1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 32'h44, 1'b0, 1'b1, 32'h48, 32'hFFFF,     1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0};

    for (int i = 0; i < 14; i++)
      cyc(vt[i].r, vt[i].iv, vt[i].ia, vt[i].dv, vt[i].dwe, vt[i].da, vt[i].dwd,
          vt[i].eir, vt[i].edr);

    // Contention for four cycles straight out of reset.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      cyc(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h34, 32'h0, (k % 2) == 0, (k % 2) == 1);
`else
      cyc(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h34, 32'h0, 1'b0, 1'b1);
`endif
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Same-cycle accept and response, then a lone IF after contention.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // IF accepted, then reset: response must be dropped.
    cyc(1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
